stepper_pulse_gen: RTL

- Parametrised N-channel step/direction pulse generator in FPGA fabric; successor to the fixed five-stepper speed/steps PIO arrangement.
- Per channel, HPS software writes a step period and a signed step count, then strobes start.
- Block emits timed step pulses with direction setup, counts issued steps for read-back, and signals completion.
- Sits between the HPS-facing PIO/register exports and the stepper driver pins.

---
 rtl/stepper_pulse_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stepper_pulse_gen.sv
// Step/dir pulse generator, N_CH independent channels; endstop stop enabled by `STEPPER_ENDSTOP_EN.
// Latency: first step rises DIR_SETUP+1 cycles after an accepted start, then one per latched period.
// Backpressure: none; start is dropped unless the channel is idle and abort is low.
module stepper_pulse_gen #(
  parameter int N_CH      = 5,
  parameter int CNT_W     = 32,
  parameter int PULSE_W   = 10,
  parameter int DIR_SETUP = 5
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [N_CH*CNT_W-1:0] speed,
  input  logic [N_CH*CNT_W-1:0] steps_cmd,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       abort,
  input  logic [N_CH-1:0]       endstop,
  output logic [N_CH-1:0]       step_out,
  output logic [N_CH-1:0]       dir_out,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       endstop_hit,
  output logic [N_CH*CNT_W-1:0] steps_done
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(PULSE_W + 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [N_CH-1:0] es_sync;

`ifdef STEPPER_ENDSTOP_EN
  logic [N_CH-1:0] es_meta;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      es_meta <= '0;
      es_sync <= '0;
    end else begin
      es_meta <= endstop;
      es_sync <= es_meta;
    end
  end
`else
  logic unused_endstop;
  assign unused_endstop = ^endstop;
  assign es_sync        = '0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           st, st_nxt;
    logic [CNT_W-1:0] per, rem, cnt, cnt_nxt, sdone;
    logic [CNT_W-1:0] spd, cmd, mag;
    logic             dir, hit, dn, abort_pend, es_pend;
    logic             accept, rise, stop_idle, finish, stop_req;

    assign spd      = speed[i*CNT_W +: CNT_W];
    assign cmd      = steps_cmd[i*CNT_W +: CNT_W];
    assign mag      = cmd[CNT_W-1] ? -cmd : cmd;
    assign stop_req = abort[i] | es_sync[i];

    always_comb begin
      st_nxt    = st;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      rise      = 1'b0;
      stop_idle = 1'b0;
      finish    = 1'b0;
      case (st)
        IDLE: begin
          if (start[i] && !abort[i]) begin
            accept = 1'b1;
            if (mag != '0) begin
              st_nxt  = SETUP;
              cnt_nxt = SETUP_LD;
            end
          end
        end
        SETUP: begin
          if (stop_req) begin
            st_nxt    = IDLE;
            stop_idle = 1'b1;
          end else if (cnt == '0) begin
            st_nxt  = HIGH;
            cnt_nxt = HIGH_LD;
            rise    = 1'b1;
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
        HIGH: begin
          // A stop seen during the pulse is held until the pulse has its full width.
          if (cnt == '0) begin
            if (stop_req || abort_pend || es_pend) begin
              st_nxt    = IDLE;
              stop_idle = 1'b1;
            end else begin
              st_nxt  = LOW;
              cnt_nxt = per - MIN_PER;
            end
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
        LOW: begin
          if (stop_req) begin
            st_nxt    = IDLE;
            stop_idle = 1'b1;
          end else if (cnt == '0) begin
            if (rem == '0) begin
              st_nxt = IDLE;
              finish = 1'b1;
            end else begin
              st_nxt  = HIGH;
              cnt_nxt = HIGH_LD;
              rise    = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        st         <= IDLE;
        cnt        <= '0;
        per        <= '0;
        rem        <= '0;
        sdone      <= '0;
        dir        <= 1'b0;
        hit        <= 1'b0;
        dn         <= 1'b0;
        abort_pend <= 1'b0;
        es_pend    <= 1'b0;
      end else begin
        st         <= st_nxt;
        cnt        <= cnt_nxt;
        dn         <= finish | (accept && (mag == '0));
        abort_pend <= (st == HIGH) && (st_nxt == HIGH) && (abort_pend | abort[i]);
        es_pend    <= (st == HIGH) && (st_nxt == HIGH) && (es_pend | es_sync[i]);
        if (accept) begin
          per   <= (spd < MIN_PER) ? MIN_PER : spd;
          rem   <= mag;
          dir   <= ~cmd[CNT_W-1];
          sdone <= '0;
          hit   <= 1'b0;
        end
        if (rise) begin
          rem   <= rem - ONE;
          sdone <= sdone + ONE;
        end
        if (stop_idle) hit <= es_sync[i] | es_pend;
      end
    end

    assign step_out[i]                 = (st == HIGH);
    assign busy[i]                     = (st != IDLE);
    assign dir_out[i]                  = dir;
    assign done[i]                     = dn;
    assign endstop_hit[i]              = hit;
    assign steps_done[i*CNT_W +: CNT_W] = sdone;
  end

endmodule
